// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: shares one program ROM port between
// the fetch unit and a loader, then requests a CPU restart after a load.
module imem_port_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] if_adr,
  output logic [31:0] if_data,
  output logic        if_stall,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [13:0] ld_adr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        ld_done,
  output logic        rom_en,
  output logic        rom_we,
  output logic [13:0] rom_adr,
  output logic [31:0] rom_din,
  input  logic [31:0] rom_dout,
  output logic        cpu_rst_req,
  output logic [14:0] ld_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD,
    RESTART
  } state_e;

  localparam logic [14:0] CntMax = 15'h4000;

  state_e      state_q, state_d;
  logic        rcnt_q, rcnt_d;
  logic [14:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (ld_start) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (ld_valid && cnt_q != CntMax)
          cnt_d = cnt_q + 15'd1;
        if (ld_done) begin
          state_d = RESTART;
          rcnt_d  = 1'b0;
        end
      end
      RESTART: begin
        rcnt_d = 1'b1;
        if (rcnt_q) begin
          state_d = RUN;
          rcnt_d  = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RUN;
      rcnt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by reset so an abort never writes or pulses restart.
  logic in_run, in_load, in_rst;
  assign in_run  = reset && state_q == RUN;
  assign in_load = reset && state_q == LOAD;
  assign in_rst  = reset && state_q == RESTART;

  assign if_data     = in_run ? rom_dout : 32'h0000_0000;
  assign if_stall    = reset && state_q != RUN;
  assign busy        = reset && state_q != RUN;
  assign ld_ready    = in_load;
  assign rom_we      = in_load && ld_valid;
  assign rom_en      = in_run || (in_load && ld_valid);
  assign rom_adr     = in_load ? ld_adr : if_adr;
  assign rom_din     = ld_data;
  assign cpu_rst_req = in_rst;
  assign ld_count    = cnt_q;

endmodule
